// File: rtl/sonic_vc_tx_pkg.sv
// Shared types and constants for the virtual-channel TX gearbox.
// The beat struct matches the bit order used by the upstream TX FIFO.
package sonic_vc_tx_pkg;

    localparam int BEAT_W       = 128;
    localparam int WORD_W       = 64;
    localparam int BEAT_EMPTY_W = 2;

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_GAP = 2'd2
    } state_t;

    typedef struct packed {
        logic                    sop;
        logic                    eop;
        logic [BEAT_EMPTY_W-1:0] empty;
        logic                    error;
        logic [BEAT_W-1:0]       data;
    } beat_t;

    // Select the upper (first on the wire) or lower 64-bit half of a beat.
    function automatic logic [WORD_W-1:0] beat_half(input beat_t b, input logic upper);
        return upper ? b.data[BEAT_W-1 -: WORD_W] : b.data[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/sonic_vc_tx_rl1_buf.sv
// Two-entry buffer in front of a ready-latency-1 source. Ready is derived
// from registered occupancy plus the beat that may still be in flight.
module sonic_vc_tx_rl1_buf
    import sonic_vc_tx_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  beat_t push_beat,
    input  logic  push_valid,
    output logic  push_ready,
    input  logic  pop,
    output beat_t head_beat,
    output logic  head_valid,
    output logic  overflow
);

    logic [1:0] occ_reg;
    logic [1:0] occ_next;
    logic       rdy_q_reg;
    logic       run_reg;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic       ovf_reg;
    logic       do_pop;
    logic       do_push;
    logic       drop;

    assign do_pop  = pop & (occ_reg != 2'd0);
    // A full buffer can still take a beat if the head leaves in the same cycle.
    assign do_push = push_valid & ((occ_reg != 2'd2) | do_pop);
    assign drop    = push_valid & ~do_push;

    // run_reg holds ready low throughout reset and releases it one edge later.
    assign push_ready = run_reg & ((occ_reg + {1'b0, rdy_q_reg}) < 2'd2);

    always_comb begin
        occ_next = occ_reg;
        case ({do_push, do_pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_reg    <= 2'd0;
            rdy_q_reg  <= 1'b0;
            run_reg    <= 1'b0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            occ_reg   <= occ_next;
            rdy_q_reg <= push_ready;
            run_reg   <= 1'b1;
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            beat_t slot_reg;
            always_ff @(posedge clock) begin
                if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= push_beat;
                end
            end
        end
    endgenerate

    assign head_beat  = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;
    assign head_valid = (occ_reg != 2'd0);
    assign overflow   = ovf_reg;

endmodule

// File: rtl/sonic_vc_tx_gearbox.sv
// Splits 128-bit FIFO beats into 64-bit words (upper half first), inserts
// an idle gap after each packet and counts packets sent downstream.
module sonic_vc_tx_gearbox
    import sonic_vc_tx_pkg::*;
#(
    parameter int IPG_CYCLES = 3,
    parameter int CNT_W      = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BEAT_W-1:0]       avalonst_sink_data,
    input  logic [BEAT_EMPTY_W-1:0] avalonst_sink_empty,
    input  logic                    avalonst_sink_startofpacket,
    input  logic                    avalonst_sink_endofpacket,
    input  logic                    avalonst_sink_error,
    input  logic                    avalonst_sink_valid,
    output logic                    avalonst_sink_ready,
    output logic [WORD_W-1:0]       avalonst_source_data,
    output logic                    avalonst_source_empty,
    output logic                    avalonst_source_startofpacket,
    output logic                    avalonst_source_endofpacket,
    output logic                    avalonst_source_error,
    output logic                    avalonst_source_valid,
    input  logic                    avalonst_source_ready,
    output logic [CNT_W-1:0]        pkt_count,
    output logic                    overflow_err
);

    localparam int GAP_W      = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam int GAP_LAST_I = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_LAST_I[GAP_W-1:0];
    localparam state_t AFTER_EOP = (IPG_CYCLES > 0) ? S_GAP : S_HI;

    beat_t              sink_beat;
    beat_t              head_beat;
    logic               head_valid;
    logic               pop;
    logic               accept;
    logic               hi_last;
    state_t             state_reg;
    state_t             state_next;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_next;
    logic [CNT_W-1:0]   pkt_count_reg;

    assign sink_beat = {avalonst_sink_startofpacket, avalonst_sink_endofpacket,
                        avalonst_sink_empty, avalonst_sink_error, avalonst_sink_data};

    sonic_vc_tx_rl1_buf u_buf (
        .clock      (clock),
        .reset      (reset),
        .push_beat  (sink_beat),
        .push_valid (avalonst_sink_valid),
        .push_ready (avalonst_sink_ready),
        .pop        (pop),
        .head_beat  (head_beat),
        .head_valid (head_valid),
        .overflow   (overflow_err)
    );

    // With two or more empty words the low half carries nothing to send.
    assign hi_last = head_beat.eop & head_beat.empty[1];
    assign accept  = avalonst_source_valid & avalonst_source_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= S_HI;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = '0;
        unique case (state_reg)
            S_HI: begin
                if (accept) begin
                    state_next = hi_last ? AFTER_EOP : S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_next = head_beat.eop ? AFTER_EOP : S_HI;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_HI;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_HI;
        endcase
    end

    always_comb begin
        avalonst_source_valid         = 1'b0;
        avalonst_source_data          = beat_half(head_beat, 1'b1);
        avalonst_source_startofpacket = 1'b0;
        avalonst_source_endofpacket   = 1'b0;
        avalonst_source_empty         = 1'b0;
        avalonst_source_error         = head_beat.error;
        pop                           = 1'b0;
        unique case (state_reg)
            S_HI: begin
                avalonst_source_valid         = head_valid;
                avalonst_source_startofpacket = head_beat.sop;
                avalonst_source_endofpacket   = hi_last;
                avalonst_source_empty         = hi_last & head_beat.empty[0];
                pop                           = head_valid & avalonst_source_ready & hi_last;
            end
            S_LO: begin
                avalonst_source_valid       = head_valid;
                avalonst_source_data        = beat_half(head_beat, 1'b0);
                avalonst_source_endofpacket = head_beat.eop;
                avalonst_source_empty       = head_beat.eop & head_beat.empty[0];
                pop                         = head_valid & avalonst_source_ready;
            end
            default: begin
                avalonst_source_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count_reg <= '0;
        end else if (accept && avalonst_source_endofpacket) begin
            pkt_count_reg <= pkt_count_reg + 1'b1;
        end
    end

    assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_sonic_vc_tx_gearbox.sv
// Randomized bench for the TX gearbox: a packet-level model predicts the
// 64-bit word stream, idle gaps, packet count and overflow flag.
module tb_sonic_vc_tx_gearbox;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        empty;
        logic        err;
    } word_t;

    typedef struct {
        logic [127:0] d;
        logic [1:0]   e;
        logic         sop;
        logic         eop;
        logic         err;
    } tbeat_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] snk_data  [2];
    logic [1:0]   snk_empty [2];
    logic         snk_sop   [2];
    logic         snk_eop   [2];
    logic         snk_err   [2];
    logic         snk_valid [2];
    logic         snk_ready [2];
    logic [63:0]  src_data  [2];
    logic         src_empty [2];
    logic         src_sop   [2];
    logic         src_eop   [2];
    logic         src_err   [2];
    logic         src_valid [2];
    logic         src_ready [2];
    logic [31:0]  pkt_cnt   [2];
    logic         ovf       [2];

    always #5 clock = ~clock;

    // Instance 0 uses a 3-cycle gap, instance 1 runs back-to-back.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            sonic_vc_tx_gearbox #(
                .IPG_CYCLES ((gi == 0) ? 3 : 0),
                .CNT_W      (32)
            ) u_dut (
                .clock                         (clock),
                .reset                         (reset),
                .avalonst_sink_data            (snk_data[gi]),
                .avalonst_sink_empty           (snk_empty[gi]),
                .avalonst_sink_startofpacket   (snk_sop[gi]),
                .avalonst_sink_endofpacket     (snk_eop[gi]),
                .avalonst_sink_error           (snk_err[gi]),
                .avalonst_sink_valid           (snk_valid[gi]),
                .avalonst_sink_ready           (snk_ready[gi]),
                .avalonst_source_data          (src_data[gi]),
                .avalonst_source_empty         (src_empty[gi]),
                .avalonst_source_startofpacket (src_sop[gi]),
                .avalonst_source_endofpacket   (src_eop[gi]),
                .avalonst_source_error         (src_err[gi]),
                .avalonst_source_valid         (src_valid[gi]),
                .avalonst_source_ready         (src_ready[gi]),
                .pkt_count                     (pkt_cnt[gi]),
                .overflow_err                  (ovf[gi])
            );
        end
    endgenerate

    int     total = 0;
    int     bad   = 0;
    int     sel   = 0;
    int     ipg_of [2] = '{3, 0};
    int     rdy_pct = 100;
    int     push_pct = 100;
    bit     force_push = 0;
    word_t  exp_q [$];
    tbeat_t pend_q [$];
    int     model_pkts = 0;
    int     gap_left = 0;
    bit     hold_valid = 0;
    word_t  hold_w;
    bit     exp_ovf = 0;
    bit     rdy_prev = 0;
    int     cyc = 0;
    int     words_acc = 0;
    int     first_acc = -1;
    int     last_acc = -1;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t obs_word(input int s);
        word_t w;
        w.data  = src_data[s];
        w.sop   = src_sop[s];
        w.eop   = src_eop[s];
        w.empty = src_eop[s] ? src_empty[s] : 1'b0;
        w.err   = src_err[s];
        return w;
    endfunction

    // Word stream expected from one beat: the upper half always, the lower
    // half unless the packet ends with two or more empty 32-bit words.
    function automatic void expect_beat(input tbeat_t b);
        word_t w;
        bit    ends_hi;
        ends_hi = b.eop && (b.e >= 2'd2);
        w.data  = b.d[127:64];
        w.sop   = b.sop;
        w.eop   = ends_hi;
        w.empty = ends_hi && (b.e == 2'd3);
        w.err   = b.err;
        exp_q.push_back(w);
        if (!ends_hi) begin
            w.data  = b.d[63:0];
            w.sop   = 1'b0;
            w.eop   = b.eop;
            w.empty = b.eop && (b.e == 2'd1);
            w.err   = b.err;
            exp_q.push_back(w);
        end
    endfunction

    task automatic add_packet(input int n, input logic [1:0] last_e, input bit rand_err);
        tbeat_t b;
        for (int i = 0; i < n; i++) begin
            b.d   = {$urandom, $urandom, $urandom, $urandom};
            b.sop = (i == 0);
            b.eop = (i == n - 1);
            b.e   = (i == n - 1) ? last_e : 2'($urandom_range(3));
            b.err = rand_err ? 1'($urandom_range(1)) : 1'b0;
            pend_q.push_back(b);
        end
    endtask

    task automatic step();
        word_t  ow;
        word_t  ew;
        tbeat_t b;
        bit     r;
        @(negedge clock);
        cyc++;
        r = (int'($urandom_range(99)) < rdy_pct);
        src_ready[sel] = r;
        ow = obs_word(sel);
        check_eq("pkt_count", pkt_cnt[sel], model_pkts);
        check_eq("overflow_err", ovf[sel], exp_ovf);
        if (gap_left > 0) begin
            check_eq("gap_idle", src_valid[sel], 1'b0);
            gap_left--;
        end
        if (hold_valid) begin
            check_eq("hold_valid", src_valid[sel], 1'b1);
            check_eq("hold_fields", ow, hold_w);
        end
        if (src_valid[sel] && r) begin
            check_eq("word_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                ew = exp_q.pop_front();
                check_eq("word", ow, ew);
                words_acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                $display("acc dut%0d cyc=%0d data=%h sop=%0b eop=%0b empty=%0b err=%0b",
                         sel, cyc, ow.data, ow.sop, ow.eop, ow.empty, ow.err);
                if (ew.eop) begin
                    model_pkts++;
                    gap_left = ipg_of[sel];
                end
            end
        end
        hold_valid = src_valid[sel] && !r;
        hold_w     = ow;
        if ((force_push || rdy_prev) && pend_q.size() > 0 &&
            int'($urandom_range(99)) < push_pct) begin
            b = pend_q.pop_front();
            snk_data[sel]  = b.d;
            snk_empty[sel] = b.e;
            snk_sop[sel]   = b.sop;
            snk_eop[sel]   = b.eop;
            snk_err[sel]   = b.err;
            snk_valid[sel] = 1'b1;
            expect_beat(b);
        end else begin
            snk_valid[sel] = 1'b0;
        end
        rdy_prev = snk_ready[sel];
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && n < limit) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) step();
        check_eq("drain_timeout", exp_q.size() + pend_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            snk_valid[s] = 1'b0;
            src_ready[s] = 1'b0;
        end
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_source_valid", src_valid[s], 1'b0);
            check_eq("rst_sink_ready", snk_ready[s], 1'b0);
            check_eq("rst_pkt_count", pkt_cnt[s], 0);
            check_eq("rst_overflow_err", ovf[s], 1'b0);
        end
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        pend_q.delete();
        model_pkts = 0;
        gap_left   = 0;
        hold_valid = 0;
        exp_ovf    = 0;
        force_push = 0;
        @(negedge clock);
        check_eq("post_rst_sink_ready", snk_ready[sel], 1'b1);
        rdy_prev = snk_ready[sel];
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            snk_data[s] = '0; snk_empty[s] = '0; snk_sop[s] = 0; snk_eop[s] = 0;
            snk_err[s] = 0; snk_valid[s] = 0; src_ready[s] = 0;
        end

        // Three-beat packet, full rate, 3-cycle gap
        sel = 0;
        do_reset();
        rdy_pct = 100; push_pct = 100; words_acc = 0;
        add_packet(3, 2'd0, 0);
        drain(200);
        check_eq("t1_words", words_acc, 6);
        check_eq("t1_pkt_count", pkt_cnt[0], 1);

        // Packets ending with empty=2 and empty=3: upper half only
        words_acc = 0;
        add_packet(2, 2'd2, 0);
        add_packet(1, 2'd3, 1);
        drain(200);
        check_eq("t2_words", words_acc, 4);

        // Back-to-back single-beat packets with no gap
        sel = 1;
        do_reset();
        words_acc = 0; first_acc = -1; last_acc = -1;
        for (int i = 0; i < 8; i++) add_packet(1, 2'd1, 0);
        drain(200);
        check_eq("t3_words", words_acc, 16);
        check_eq("t3_continuous", last_acc - first_acc, 15);
        check_eq("t3_pkt_count", pkt_cnt[1], 8);

        // Random stalls and random packet shapes on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            do_reset();
            rdy_pct = 50; push_pct = 70;
            for (int i = 0; i < 20; i++)
                add_packet($urandom_range(1, 5), 2'($urandom_range(3)), 1);
            drain(5000);
        end

        // Protocol violation: three beats in a row while the output stalls
        sel = 0;
        do_reset();
        rdy_pct = 0; push_pct = 100; force_push = 1;
        for (int i = 0; i < 3; i++) add_packet(1, 2'd0, 0);
        for (int i = 0; i < 3; i++) step();
        force_push = 0;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        exp_ovf = 1;
        rdy_pct = 100;
        drain(200);
        check_eq("ovf_sticky", ovf[0], 1'b1);

        // Reset while the low half of a beat is pending
        do_reset();
        rdy_pct = 100; push_pct = 100;
        add_packet(1, 2'd0, 1);
        drain(200);
        words_acc = 0;
        add_packet(3, 2'd0, 0);
        for (int n = 0; n < 100 && words_acc < 3; n++) step();
        check_eq("mid_words", words_acc, 3);
        rdy_pct = 0;
        step();
        check_eq("mid_in_lo", {hold_valid, hold_w.sop}, 2'b10);
        do_reset();
        rdy_pct = 100;
        words_acc = 0;
        add_packet(2, 2'd1, 0);
        drain(200);
        check_eq("post_rst_words", words_acc, 4);
        check_eq("post_rst_pkt_count", pkt_cnt[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
